alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Consumer end of the ALU result interface. Captures the ALU's result, write enables and flag outputs, and owns the architectural accumulator and the Z/C status flags.
- Drives a registered one-cycle-delayed register-file write port and forwards in-flight register writes back to the ALU's regvalue input.
- Provides interrupt shadow save/restore of accumulator and flags.
- Sits between the execute stage and the register file.

Parameters:
ADDR_W, 7, register-file address width
ACCUM_RST, 8'h00, accumulator reset value

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
valid  in  1  ALU outputs valid this cycle (instruction in execute)
stall  in  1  freeze capture this cycle
result  in  8  ALU result
accum_write  in  1  ALU requests accumulator write
reg_write  in  1  ALU requests register write
z_write  in  1  ALU requests Z update
zout  in  1  ALU zero output
c_write  in  1  ALU requests C update
cout  in  1  ALU carry output
dest_addr  in  ADDR_W  destination register of the executing instruction
src_addr  in  ADDR_W  register address the ALU is reading
rf_rdata  in  8  raw register-file read data for src_addr
irq_save  in  1  pulse: copy accum/Z/C into shadow
irq_restore  in  1  pulse: load accum/Z/C from shadow
accum  out  8  architectural accumulator, to ALU accum input
regvalue  out  8  forwarded register operand, to ALU regvalue input
cin  out  1  C flag, to ALU cin
z_flag  out  1  Z flag
c_flag  out  1  C flag (same as cin)
rf_we  out  1  register-file write enable
rf_waddr  out  ADDR_W  register-file write address
rf_wdata  out  8  register-file write data

Behaviour:
Reset (async, reset_n low): all registers clear.
- accum=ACCUM_RST, Z=0, C=0.
- shadow={ACCUM_RST,0,0}.
- rf_we=0, rf_waddr=0, rf_wdata=0.

Capture occurs when cap = valid && !stall, on the rising edge.
- accum_write: accum <= result.
- z_write: Z <= zout.
- c_write: C <= cout.
- Each enable is independent; any combination is legal.

Register write pipeline (one stage):
- rf_we <= cap && reg_write.
- rf_waddr <= dest_addr and rf_wdata <= result, loaded only when cap && reg_write; otherwise held.
- rf_we is high for exactly one cycle per captured write, including when stall is high the following cycle.
- A stall never repeats a write.

Forwarding (combinational): regvalue = (rf_we && rf_waddr==src_addr) ? rf_wdata : rf_rdata. The register file is written at the end of the rf_we cycle, so no older stage needs a bypass.

Accumulator and flags need no bypass. accum, Z and C update at the capture edge and are visible to the next instruction.

Shadow control (evaluated at the same edge as capture):
- irq_save only: shadow <= next-state {accum,Z,C}, i.e. including this cycle's capture updates.
- irq_restore only: {accum,Z,C} <= shadow. Any same-cycle capture updates to accum/Z/C are discarded. The register-write pipeline still proceeds normally.
- Both high: swap. Shadow <= current registered {accum,Z,C} (pre-capture), {accum,Z,C} <= old shadow. Capture updates are discarded.
- Neither: shadow holds.

Stall:
- No accum/flag/shadow-independent capture.
- Shadow pulses are still honoured (they do not depend on valid/stall).
- Reset mid-operation: a pending rf_we is dropped immediately (rf_we=0 while reset_n low); no partial write.

Outputs cin and c_flag are the C register. All outputs are registered except regvalue.

Test Plan:
1. Reset, then check outputs: accum=00, Z=0, C=0, rf_we=0. Then valid=1, accum_write=1, result=3C, z_write=1, zout=0 -> next cycle accum=3C, Z=0, rf_we=0.
2. valid, reg_write=1, dest_addr=05, result=A5, c_write=1, cout=1 -> next cycle rf_we=1, rf_waddr=05, rf_wdata=A5, C=1. In that cycle src_addr=05, rf_rdata=11 -> regvalue=A5; src_addr=06 -> regvalue=11. The following cycle rf_we=0.
3. stall=1 with valid=1, accum_write=1, result=FF, reg_write=1 -> accum unchanged, rf_we stays 0. A write captured the prior cycle still pulses rf_we exactly once during the stall.
4. accum=12, Z=1, C=0: irq_save alongside capture accum_write result=34 -> shadow={34,1,0}. Later irq_restore with valid capture result=99, accum_write=1 -> accum=34, Z=1, C=0, and any reg_write in that cycle is still issued.
5. Swap: accum=77, C=1, shadow={34,0,0}; assert irq_save and irq_restore together -> accum=34, C=0, shadow={77,0,1}.
6. Assert reset_n low asynchronously mid-cycle while rf_we=1 -> rf_we, accum and flags go to reset values before the next clock edge.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU result consumer: owns accumulator and Z/C flags, a one-stage register-file
// write pipeline with operand forwarding, and an interrupt shadow for accum/Z/C.
module alu_writeback #(
  parameter int unsigned ADDR_W    = 7,
  parameter logic [7:0]  ACCUM_RST = 8'h00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic              stall,
  input  logic [7:0]        result,
  input  logic              accum_write,
  input  logic              reg_write,
  input  logic              z_write,
  input  logic              zout,
  input  logic              c_write,
  input  logic              cout,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        rf_rdata,
  input  logic              irq_save,
  input  logic              irq_restore,
  output logic [7:0]        accum,
  output logic [7:0]        regvalue,
  output logic              cin,
  output logic              z_flag,
  output logic              c_flag,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [7:0]        rf_wdata
);

  logic              cap;
  logic [7:0]        cap_accum;
  logic              cap_z, cap_c;
  logic [7:0]        accum_d, accum_q, sh_accum_d, sh_accum_q;
  logic              z_d, z_q, c_d, c_q;
  logic              sh_z_d, sh_z_q, sh_c_d, sh_c_q;
  logic              rf_we_d, rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_d, rf_waddr_q;
  logic [7:0]        rf_wdata_d, rf_wdata_q;

  always_comb begin
    cap       = valid && !stall;
    cap_accum = (cap && accum_write) ? result : accum_q;
    cap_z     = (cap && z_write) ? zout : z_q;
    cap_c     = (cap && c_write) ? cout : c_q;

    // Restore (alone or as part of a swap) overrides any same-cycle capture.
    if (irq_restore) begin
      accum_d = sh_accum_q;
      z_d     = sh_z_q;
      c_d     = sh_c_q;
    end else begin
      accum_d = cap_accum;
      z_d     = cap_z;
      c_d     = cap_c;
    end

    // Swap saves pre-capture state; a plain save includes this cycle's capture.
    if (irq_save && irq_restore) begin
      sh_accum_d = accum_q;
      sh_z_d     = z_q;
      sh_c_d     = c_q;
    end else if (irq_save) begin
      sh_accum_d = cap_accum;
      sh_z_d     = cap_z;
      sh_c_d     = cap_c;
    end else begin
      sh_accum_d = sh_accum_q;
      sh_z_d     = sh_z_q;
      sh_c_d     = sh_c_q;
    end

    rf_we_d    = cap && reg_write;
    rf_waddr_d = rf_we_d ? dest_addr : rf_waddr_q;
    rf_wdata_d = rf_we_d ? result : rf_wdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accum_q    <= ACCUM_RST;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      sh_accum_q <= ACCUM_RST;
      sh_z_q     <= 1'b0;
      sh_c_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      accum_q    <= accum_d;
      z_q        <= z_d;
      c_q        <= c_d;
      sh_accum_q <= sh_accum_d;
      sh_z_q     <= sh_z_d;
      sh_c_q     <= sh_c_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // The register file commits at the end of the rf_we cycle, so only this stage needs bypassing.
  always_comb begin
    regvalue = (rf_we_q && (rf_waddr_q == src_addr)) ? rf_wdata_q : rf_rdata;
  end

  assign accum    = accum_q;
  assign z_flag   = z_q;
  assign c_flag   = c_q;
  assign cin      = c_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: register-file writes are checked by a
// scoreboard monitor; accumulator, flags and forwarding are checked directly.
module tb_alu_writeback;

  localparam int unsigned ADDR_W = 7;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              valid, stall;
  logic [7:0]        result;
  logic              accum_write, reg_write, z_write, zout, c_write, cout;
  logic [ADDR_W-1:0] dest_addr, src_addr;
  logic [7:0]        rf_rdata;
  logic              irq_save, irq_restore;
  logic [7:0]        accum, regvalue;
  logic              cin, z_flag, c_flag, rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [7:0]        rf_wdata;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  alu_writeback #(.ADDR_W(ADDR_W), .ACCUM_RST(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .stall(stall),
    .result(result), .accum_write(accum_write), .reg_write(reg_write),
    .z_write(z_write), .zout(zout), .c_write(c_write), .cout(cout),
    .dest_addr(dest_addr), .src_addr(src_addr), .rf_rdata(rf_rdata),
    .irq_save(irq_save), .irq_restore(irq_restore),
    .accum(accum), .regvalue(regvalue), .cin(cin), .z_flag(z_flag),
    .c_flag(c_flag), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string name, input logic [7:0] a, input logic z, input logic c);
    chk({name, ".accum"}, {24'd0, accum}, {24'd0, a});
    chk({name, ".z"}, {31'd0, z_flag}, {31'd0, z});
    chk({name, ".c"}, {31'd0, c_flag}, {31'd0, c});
    chk({name, ".cin"}, {31'd0, cin}, {31'd0, c});
  endtask

  task automatic idle();
    valid = 0; stall = 0; result = '0; accum_write = 0; reg_write = 0;
    z_write = 0; zout = 0; c_write = 0; cout = 0; dest_addr = '0;
    irq_save = 0; irq_restore = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    wr_t w;
    valid = 1; reg_write = 1; dest_addr = a; result = d;
    w.addr = a; w.data = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every rf_we pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (reset_n && rf_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rf_we", {31'd0, rf_we}, 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("rf_waddr", {25'd0, rf_waddr}, {25'd0, w.addr});
        chk("rf_wdata", {24'd0, rf_wdata}, {24'd0, w.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset_n = 0; src_addr = '0; rf_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 8'h00, 1'b0, 1'b0);
    chk("reset.rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset.rf_waddr", {25'd0, rf_waddr}, 32'd0);
    chk("reset.rf_wdata", {24'd0, rf_wdata}, 32'd0);
    reset_n = 1;

    // 1: accumulator and Z capture
    valid = 1; accum_write = 1; result = 8'h3C; z_write = 1; zout = 0;
    tick(); idle();
    chk_state("t1", 8'h3C, 1'b0, 1'b0);
    chk("t1.rf_we", {31'd0, rf_we}, 32'd0);

    // 2: register write, C capture, forwarding
    issue_write(7'h05, 8'hA5); c_write = 1; cout = 1;
    tick(); idle();
    chk_state("t2", 8'h3C, 1'b0, 1'b1);
    chk("t2.rf_we", {31'd0, rf_we}, 32'd1);
    src_addr = 7'h05; rf_rdata = 8'h11; #1;
    chk("t2.fwd_hit", {24'd0, regvalue}, 32'hA5);
    src_addr = 7'h06; #1;
    chk("t2.fwd_miss", {24'd0, regvalue}, 32'h11);
    tick();
    chk("t2.rf_we_drop", {31'd0, rf_we}, 32'd0);
    src_addr = 7'h05; #1;
    chk("t2.no_fwd", {24'd0, regvalue}, 32'h11);

    // 3: write captured, then stalled cycles: write pulses once, nothing else captured
    issue_write(7'h09, 8'h5A);
    tick(); idle();
    stall = 1; valid = 1; accum_write = 1; result = 8'hFF; reg_write = 1; dest_addr = 7'h03;
    chk("t3.rf_we_in_stall", {31'd0, rf_we}, 32'd1);
    tick();
    chk("t3.rf_we_after", {31'd0, rf_we}, 32'd0);
    chk("t3.accum", {24'd0, accum}, 32'h3C);
    tick(); idle();
    chk("t3.rf_we_after2", {31'd0, rf_we}, 32'd0);

    // 4: save includes same-cycle capture; restore discards capture but keeps reg write
    valid = 1; accum_write = 1; result = 8'h12; z_write = 1; zout = 1; c_write = 1; cout = 0;
    tick(); idle();
    chk_state("t4.setup", 8'h12, 1'b1, 1'b0);
    valid = 1; accum_write = 1; result = 8'h34; irq_save = 1;
    tick(); idle();
    chk_state("t4.save", 8'h34, 1'b1, 1'b0);
    valid = 1; accum_write = 1; result = 8'h56; z_write = 1; zout = 0; c_write = 1; cout = 1;
    tick(); idle();
    chk_state("t4.change", 8'h56, 1'b0, 1'b1);
    issue_write(7'h07, 8'h99); accum_write = 1; z_write = 1; zout = 0; irq_restore = 1;
    tick(); idle();
    chk_state("t4.restore", 8'h34, 1'b1, 1'b0);
    chk("t4.rf_we", {31'd0, rf_we}, 32'd1);

    // 5: swap
    valid = 1; z_write = 1; zout = 0;
    tick(); idle();
    irq_save = 1;
    tick(); idle();
    valid = 1; accum_write = 1; result = 8'h77; c_write = 1; cout = 1;
    tick(); idle();
    chk_state("t5.setup", 8'h77, 1'b0, 1'b1);
    irq_save = 1; irq_restore = 1; valid = 1; accum_write = 1; result = 8'h11;
    tick(); idle();
    chk_state("t5.swap", 8'h34, 1'b0, 1'b0);
    irq_restore = 1;
    tick(); idle();
    chk_state("t5.restore", 8'h77, 1'b0, 1'b1);

    // 6: async reset drops a pending write before the monitor's sample point
    valid = 1; reg_write = 1; dest_addr = 7'h02; result = 8'hEE; accum_write = 1;
    tick(); idle();
    chk("t6.rf_we_pre", {31'd0, rf_we}, 32'd1);
    #1 reset_n = 0;
    #1;
    chk("t6.rf_we", {31'd0, rf_we}, 32'd0);
    chk("t6.rf_waddr", {25'd0, rf_waddr}, 32'd0);
    chk_state("t6", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1 reset_n = 1;
    tick(); tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
